// File: rtl/cpu_defs.sv
// Shared CPU definitions: machine width, reset vector, canonical nop and RV32 opcodes.
`timescale 1ns/1ps
package cpu_defs;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Next-PC selection: a redirect wins over sequential advance, otherwise the PC holds.
`timescale 1ns/1ps
module pc_gen
    import cpu_defs::*;
(
    input  logic [XLEN-1:0] cur_pc_i,
    input  logic [XLEN-1:0] seq_base_i,
    input  logic            advance_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] next_pc_o
);

    always_comb begin
        next_pc_o = cur_pc_i;
        if (redirect_valid_i) begin
            next_pc_o = word_align(redirect_pc_i);
        end else if (advance_i) begin
            // Wraps modulo 2^XLEN.
            next_pc_o = seq_base_i + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with a single outstanding memory request and a one-entry
// output register towards decode; redirects flush and kill in-flight responses.
`timescale 1ns/1ps
module fetch_unit
    import cpu_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            kill_q, kill_d;
    logic            inst_valid_q, inst_valid_d;

    logic out_free;
    logic req_fire;
    logic rsp_take;
    logic rsp_load;

    assign out_free = !inst_valid_q || inst_ready;
    assign req_fire = imem_req && imem_gnt;
    assign rsp_take = (state_q == S_WAIT) && imem_rvalid;
    // A redirect in the same cycle as the response discards it.
    assign rsp_load = rsp_take && !kill_q && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (req_fire) state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (state_q == S_REQ) begin
            imem_req = out_free;
        end
    end

    pc_gen u_pc_gen (
        .cur_pc_i         (pc_q),
        .seq_base_i       (req_pc_q),
        .advance_i        (rsp_load),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .next_pc_o        (pc_d)
    );

    always_comb begin
        req_pc_d  = req_fire ? pc_q : req_pc_q;
        inst_d    = rsp_load ? imem_rdata : inst_q;
        inst_pc_d = rsp_load ? req_pc_q : inst_pc_q;

        // The response retires the single outstanding request, so it always clears kill.
        kill_d = kill_q;
        if (rsp_take) begin
            kill_d = 1'b0;
        end else if (redirect_valid && ((state_q == S_WAIT) || req_fire)) begin
            kill_d = 1'b1;
        end

        inst_valid_d = inst_valid_q;
        if (redirect_valid) begin
            inst_valid_d = 1'b0;
        end else if (rsp_load) begin
            inst_valid_d = 1'b1;
        end else if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= INST_NOP;
            inst_pc_q    <= RESET_PC;
        end else begin
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int total = 0;
    int bad   = 0;

    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] granted[$];
    int          grant_cyc[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_w[$];
    int          cyc;
    logic        saw_req;
    logic [31:0] saw_addr;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pend = 1'b0;
        pend_addr = 32'h0;
        granted.delete();
        grant_cyc.delete();
        cons_pc.delete();
        cons_w.delete();
        cyc = 0;
    endtask

    // One clock of a memory that grants when g=1 and answers the outstanding request when rv=1.
    task automatic mem_cycle(input logic g, input logic rv);
        logic fired;
        logic rsp;
        imem_gnt = g;
        imem_rvalid = rv & pend;
        imem_rdata = word(pend_addr);
        #1;
        saw_req = imem_req;
        saw_addr = imem_addr;
        fired = imem_req & g;
        rsp = imem_rvalid;
        if (inst_valid && inst_ready && !redirect_valid) begin
            cons_pc.push_back(inst_pc);
            cons_w.push_back(inst);
        end
        @(posedge clk);
        #1;
        if (rsp) pend = 1'b0;
        if (fired) begin
            pend = 1'b1;
            pend_addr = saw_addr;
            granted.push_back(saw_addr);
            grant_cyc.push_back(cyc);
        end
        cyc++;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (4) mem_cycle(1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
        total++; if (inst !== 32'h0000_0013) begin bad++; $display("FAIL rst_inst got=%h exp=00000013", inst); end
        total++; if (inst_pc !== RST_PC) begin bad++; $display("FAIL rst_inst_pc got=%h exp=%h", inst_pc, RST_PC); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_imem_addr got=%h exp=%h", imem_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        do_reset();
        inst_ready = 1'b1;
        repeat (9) mem_cycle(1'b1, 1'b1);
        total++;
        if (granted.size() < 4) begin
            bad++; $display("FAIL seq_grant_count got=%0d exp=4", granted.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (granted[i] !== RST_PC + 32'(4 * i)) begin
                    bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, granted[i], RST_PC + 32'(4 * i));
                end
                total++;
                if (grant_cyc[i] !== 1 + 2 * i) begin
                    bad++; $display("FAIL seq_grant_cycle[%0d] got=%0d exp=%0d", i, grant_cyc[i], 1 + 2 * i);
                end
            end
        end
        total++;
        if (cons_pc.size() < 3) begin
            bad++; $display("FAIL seq_consumed_count got=%0d exp=3", cons_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cons_pc[i] !== RST_PC + 32'(4 * i) || cons_w[i] !== word(RST_PC + 32'(4 * i))) begin
                    bad++; $display("FAIL seq_inst[%0d] got pc=%h w=%h exp pc=%h w=%h", i, cons_pc[i], cons_w[i],
                                    RST_PC + 32'(4 * i), word(RST_PC + 32'(4 * i)));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 10 && !inst_valid; i++) mem_cycle(1'b1, 1'b1);
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin
            bad++; $display("FAIL stall_first_inst got valid=%b pc=%h exp valid=1 pc=%h", inst_valid, inst_pc, RST_PC);
        end
        repeat (5) begin
            mem_cycle(1'b1, 1'b1);
            total++;
            if (saw_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== word(RST_PC)) begin
                bad++; $display("FAIL stall_hold got req=%b valid=%b pc=%h inst=%h exp req=0 valid=1 pc=%h inst=%h",
                                saw_req, inst_valid, inst_pc, inst, RST_PC, word(RST_PC));
            end
        end
        inst_ready = 1'b1;
        mem_cycle(1'b1, 1'b1);
        total++;
        if (saw_req !== 1'b1 || saw_addr !== RST_PC + 32'h4) begin
            bad++; $display("FAIL stall_resume got req=%b addr=%h exp req=1 addr=%h", saw_req, saw_addr, RST_PC + 32'h4);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 12 && !(pend && pend_addr == 32'h8); i++) mem_cycle(1'b1, 1'b1);
        total++;
        if (!(pend && pend_addr == 32'h8)) begin
            bad++; $display("FAIL redir_setup got pend=%b addr=%h exp pend=1 addr=00000008", pend, pend_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        mem_cycle(1'b1, 1'b0);
        redirect_valid = 1'b0;
        cons_pc.delete();
        cons_w.delete();
        for (int i = 0; i < 12 && cons_pc.size() == 0; i++) mem_cycle(1'b1, 1'b1);
        total++;
        if (cons_pc.size() == 0) begin
            bad++; $display("FAIL redir_wait_next got=none exp=00000100");
        end else if (cons_pc[0] !== 32'h100 || cons_w[0] !== word(32'h100)) begin
            bad++; $display("FAIL redir_wait_next got pc=%h w=%h exp pc=00000100 w=%h", cons_pc[0], cons_w[0], word(32'h100));
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 6 && !pend; i++) mem_cycle(1'b1, 1'b1);
        total++;
        if (pend !== 1'b1) begin bad++; $display("FAIL redir_rv_setup got pend=%b exp=1", pend); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        mem_cycle(1'b1, 1'b1);
        redirect_valid = 1'b0;
        total++;
        if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_rv_discard got valid=%b exp=0", inst_valid); end
        mem_cycle(1'b1, 1'b1);
        total++;
        if (saw_req !== 1'b1 || saw_addr !== 32'h200) begin
            bad++; $display("FAIL redir_rv_addr got req=%b addr=%h exp req=1 addr=00000200", saw_req, saw_addr);
        end
    endtask

    task automatic test_gnt_delay();
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 12 && granted.size() < 3; i++) mem_cycle(1'b1, 1'b1);
        total++;
        if (granted.size() !== 3) begin bad++; $display("FAIL gnt_setup got=%0d exp=3", granted.size()); end
        mem_cycle(1'b0, 1'b1);
        repeat (3) begin
            mem_cycle(1'b0, 1'b1);
            total++;
            if (saw_req !== 1'b1 || saw_addr !== 32'hC) begin
                bad++; $display("FAIL gnt_hold got req=%b addr=%h exp req=1 addr=0000000c", saw_req, saw_addr);
            end
        end
        mem_cycle(1'b1, 1'b1);
        total++;
        if (saw_req !== 1'b1 || saw_addr !== 32'hC || granted.size() !== 4) begin
            bad++; $display("FAIL gnt_accept got req=%b addr=%h grants=%0d exp req=1 addr=0000000c grants=4",
                            saw_req, saw_addr, granted.size());
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 6 && !pend; i++) mem_cycle(1'b1, 1'b1);
        total++;
        if (pend !== 1'b1) begin bad++; $display("FAIL rstwait_setup got pend=%b exp=1", pend); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== RST_PC) begin
            bad++; $display("FAIL rstwait_async got valid=%b req=%b addr=%h exp 0 0 %h", inst_valid, imem_req, imem_addr, RST_PC);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        pend = 1'b0;
        granted.delete();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if (inst_valid !== 1'b0) begin bad++; $display("FAIL rstwait_late_rsp got valid=%b exp=0", inst_valid); end
        end
        imem_rvalid = 1'b0;
        mem_cycle(1'b1, 1'b1);
        total++;
        if (saw_req !== 1'b1 || saw_addr !== RST_PC) begin
            bad++; $display("FAIL rstwait_first_fetch got req=%b addr=%h exp req=1 addr=%h", saw_req, saw_addr, RST_PC);
        end
    endtask

    // Model: next fetch address, the one outstanding request, and the queue of words owed to decode.
    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] m_next;
        logic [31:0] m_addr;
        logic        m_out;
        logic        m_kill;
        logic        exp_req;
        logic        fire;
        logic        rsp;
        int          age;
        do_reset();
        m_next = RST_PC;
        m_addr = 32'h0;
        m_out = 1'b0;
        m_kill = 1'b0;
        age = 0;
        for (int n = 0; n < 600; n++) begin
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc = $urandom;
            inst_ready = ($urandom % 4) != 0;
            imem_gnt = $urandom_range(0, 1);
            imem_rvalid = m_out ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
            imem_rdata = m_out ? word(m_addr) : $urandom;
            #1;
            exp_req = (age >= 1) && !m_out && (q.size() == 0 || inst_ready);
            total++;
            if (imem_req !== exp_req) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", n, imem_req, exp_req); end
            if (exp_req) begin
                total++;
                if (imem_addr !== m_next) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", n, imem_addr, m_next); end
            end
            total++;
            if (inst_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, inst_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                total++;
                if (inst_pc !== q[0] || inst !== word(q[0])) begin
                    bad++; $display("FAIL rnd_inst cyc=%0d got pc=%h w=%h exp pc=%h w=%h", n, inst_pc, inst, q[0], word(q[0]));
                end
            end
            fire = exp_req && imem_gnt;
            rsp = imem_rvalid && m_out;
            @(posedge clk);
            #1;
            if (q.size() != 0 && inst_ready) void'(q.pop_front());
            if (rsp) begin
                m_out = 1'b0;
                if (!m_kill && !redirect_valid) begin
                    q.push_back(m_addr);
                    m_next = m_addr + 32'd4;
                end
            end
            if (fire) begin
                m_out = 1'b1;
                m_addr = m_next;
                m_kill = 1'b0;
            end
            if (redirect_valid) begin
                q.delete();
                m_next = {redirect_pc[31:2], 2'b00};
                if (m_out) m_kill = 1'b1;
            end
            age++;
        end
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_gnt_delay();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
